// File: rtl/ro_sample_window_pkg.sv
// ro_sample_window_pkg: shared widths, count/sample types, FSM states and the saturating add.
package ro_sample_window_pkg;
   localparam int ADD_WIDTH   = 19;
   localparam int FIFO_WIDTH  = 20;
   localparam int COUNT_WIDTH = 43;
   typedef logic [COUNT_WIDTH-1:0] count_t;
   typedef logic [FIFO_WIDTH-1:0] sample_t;
   typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DONE} state_t;
   // Returns {clamped, min(a+b, 2^FIFO_WIDTH-1)}; the carry of the FIFO_WIDTH+1 bit sum is the clamp flag.
   function automatic logic [FIFO_WIDTH:0] sat_add(input sample_t a, input sample_t b);
      logic [FIFO_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[FIFO_WIDTH] ? {1'b1, {FIFO_WIDTH{1'b1}}} : s;
   endfunction
endpackage

// File: rtl/ro_sample_window_if.sv
// ro_sample_window_if: control, RO sum, FIFO write and status signals of the sample window.
//   master drives go/stop/num_samples/collect_cycles/ro_sum_valid/ro_sum/fifo_full,
//   slave (the window block) drives fifo_wr_en/fifo_wr_data/busy/done/saturated/dropped.
interface ro_sample_window_if;
   import ro_sample_window_pkg::*;
   logic go, stop, ro_sum_valid, fifo_full;
   count_t num_samples, collect_cycles;
   logic [ADD_WIDTH-1:0] ro_sum;
   logic fifo_wr_en, busy, done, saturated;
   sample_t fifo_wr_data;
   count_t dropped;
   modport master (
      output go, stop, num_samples, collect_cycles, ro_sum_valid, ro_sum, fifo_full,
      input  fifo_wr_en, fifo_wr_data, busy, done, saturated, dropped
   );
   modport slave (
      input  go, stop, num_samples, collect_cycles, ro_sum_valid, ro_sum, fifo_full,
      output fifo_wr_en, fifo_wr_data, busy, done, saturated, dropped
   );
endinterface

// File: rtl/ro_sample_window_sat_accum.sv
// ro_sat_accum: saturating window accumulator with clear, enable and sticky saturate flag.
//   clr_i clears the accumulator (wins over en_i), sat_clr_i clears the sticky flag,
//   en_i adds add_i; sum_o is the saturated acc+add_i seen this cycle, sat_o the sticky clamp flag.
module ro_sat_accum
   import ro_sample_window_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 sat_clr_i,
   input  logic                 en_i,
   input  logic [ADD_WIDTH-1:0] add_i,
   output sample_t              sum_o,
   output logic                 sat_o
);
   sample_t acc_q, acc_d;
   logic sat_q, sat_d, clamp;
   // A closing beat clears and adds in the same cycle, so its clamp still reaches the sticky flag.
   always_comb begin
      {clamp, sum_o} = sat_add(acc_q, sample_t'(add_i));
      acc_d = clr_i ? '0 : en_i ? sum_o : acc_q;
      sat_d = !sat_clr_i && (sat_q || (en_i && clamp));
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   assign sat_o = sat_q;
endmodule

// File: rtl/ro_sample_window.sv
// ro_sample_window: accumulates RO sums over programmed windows and pushes one saturated sample per window.
//   clk/rst: clock and asynchronous active-high reset; bus: slave side of ro_sample_window_if.
module ro_sample_window
   import ro_sample_window_pkg::*;
(
   input logic               clk,
   input logic               rst,
   ro_sample_window_if.slave bus
);
   state_t state_q, state_d;
   count_t num_q, num_d, cyc_q, cyc_d, beat_q, beat_d, samp_q, samp_d, drop_q, drop_d, samp_inc;
   sample_t hold_q, hold_d, wr_data_q, wr_data_d, sum;
   logic wr_en_q, wr_en_d, acc_clr, acc_en, sat_clr, sat;
   ro_sat_accum u_acc (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (acc_clr),
      .sat_clr_i (sat_clr),
      .en_i      (acc_en),
      .add_i     (bus.ro_sum),
      .sum_o     (sum),
      .sat_o     (sat)
   );
   assign samp_inc = samp_q + count_t'(1);
   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      cyc_d     = cyc_q;
      beat_d    = beat_q;
      samp_d    = samp_q;
      drop_d    = drop_q;
      hold_d    = hold_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      acc_clr   = 1'b0;
      acc_en    = 1'b0;
      sat_clr   = 1'b0;
      case (state_q)
         IDLE, DONE:
            if (bus.go) begin
               num_d   = bus.num_samples;
               cyc_d   = (bus.collect_cycles == '0) ? count_t'(1) : bus.collect_cycles;
               beat_d  = '0;
               samp_d  = '0;
               drop_d  = '0;
               acc_clr = 1'b1;
               sat_clr = 1'b1;
               state_d = (bus.num_samples == '0) ? DONE : COLLECT;
            end
         COLLECT:
            // stop outranks a closing beat: the partial window is thrown away with no write.
            if (bus.stop) begin
               beat_d  = '0;
               acc_clr = 1'b1;
               state_d = DONE;
            end else if (bus.ro_sum_valid) begin
               acc_en = 1'b1;
               if (beat_q == cyc_q - count_t'(1)) begin
                  beat_d  = '0;
                  acc_clr = 1'b1;
                  if (bus.fifo_full) begin
                     hold_d  = sum;
                     state_d = HOLD;
                  end else begin
                     wr_en_d   = 1'b1;
                     wr_data_d = sum;
                     samp_d    = samp_inc;
                     state_d   = (samp_inc == num_q) ? DONE : COLLECT;
                  end
               end else
                  beat_d = beat_q + count_t'(1);
            end
         HOLD:
            if (bus.stop)
               state_d = DONE;
            else begin
               if (bus.ro_sum_valid)
                  drop_d = (&drop_q) ? drop_q : drop_q + count_t'(1);
               if (!bus.fifo_full) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = hold_q;
                  samp_d    = samp_inc;
                  state_d   = (samp_inc == num_q) ? DONE : COLLECT;
               end
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q   <= IDLE;
         num_q     <= '0;
         cyc_q     <= '0;
         beat_q    <= '0;
         samp_q    <= '0;
         drop_q    <= '0;
         hold_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         cyc_q     <= cyc_d;
         beat_q    <= beat_d;
         samp_q    <= samp_d;
         drop_q    <= drop_d;
         hold_q    <= hold_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
      end
   assign bus.fifo_wr_en   = wr_en_q;
   assign bus.fifo_wr_data = wr_data_q;
   assign bus.busy         = (state_q == COLLECT) || (state_q == HOLD);
   // done waits out the final write pulse so it rises the cycle after the last sample.
   assign bus.done         = (state_q == DONE) && !wr_en_q;
   assign bus.saturated    = sat;
   assign bus.dropped      = drop_q;
endmodule

// File: tb/tb_ro_sample_window.sv
// tb_ro_sample_window: directed scoreboard bench for ro_sample_window.
module tb_ro_sample_window;
   import ro_sample_window_pkg::*;
   logic clk, rst;
   int checks = 0, errors = 0, cyc_n = 0;
   sample_t exp_q[$];
   int wr_times[$];
   ro_sample_window_if ro_if ();
   ro_sample_window dut (.clk(clk), .rst(rst), .bus(ro_if));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(negedge clk) begin
      if (!rst && ro_if.fifo_wr_en) begin
         wr_times.push_back(cyc_n);
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write observed=%0h expected=none", ro_if.fifo_wr_data);
         end
         if (exp_q.size() != 0) begin
            sample_t e;
            e = exp_q.pop_front();
            checks++;
            assert (ro_if.fifo_wr_data === e) else begin
               errors++;
               $error("FAIL wr_data observed=%0h expected=%0h", ro_if.fifo_wr_data, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_gaps(input int n, input int gap);
      chk("wr_count", 64'(wr_times.size()), 64'(n));
      for (int i = 1; i < n && i < wr_times.size(); i++)
         chk("wr_gap", 64'(wr_times[i] - wr_times[i-1]), 64'(gap));
   endtask

   task automatic start(input count_t ns, input count_t cc);
      ro_if.num_samples    = ns;
      ro_if.collect_cycles = cc;
      ro_if.go             = 1'b1;
      cyc();
      ro_if.go = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(ro_if.busy), 64'd0);
      chk({tag, "_done"}, 64'(ro_if.done), 64'd0);
      chk({tag, "_wr_en"}, 64'(ro_if.fifo_wr_en), 64'd0);
      chk({tag, "_wr_data"}, 64'(ro_if.fifo_wr_data), 64'd0);
      chk({tag, "_saturated"}, 64'(ro_if.saturated), 64'd0);
      chk({tag, "_dropped"}, 64'(ro_if.dropped), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      ro_if.go = 1'b0;
      ro_if.stop = 1'b0;
      ro_if.num_samples = '0;
      ro_if.collect_cycles = '0;
      ro_if.ro_sum_valid = 1'b0;
      ro_if.ro_sum = '0;
      ro_if.fifo_full = 1'b0;
      cyc();
      cyc();
      chk_all_zero("reset");
      rst = 1'b0;
      cyc();
      // num_samples = 0: done right after go, no writes
      start(0, 4);
      chk("ns0_done", 64'(ro_if.done), 64'd1);
      chk("ns0_busy", 64'(ro_if.busy), 64'd0);
      repeat (3) cyc();
      // basic run: 3 windows of 4 beats of 10
      ro_if.ro_sum_valid = 1'b1;
      ro_if.ro_sum = 19'd10;
      repeat (3) exp_q.push_back(20'd40);
      wr_times.delete();
      start(3, 4);
      chk("basic_busy", 64'(ro_if.busy), 64'd1);
      repeat (12) cyc();
      chk("basic_last_wr", 64'(ro_if.fifo_wr_en), 64'd1);
      chk("basic_done_early", 64'(ro_if.done), 64'd0);
      cyc();
      chk("basic_done", 64'(ro_if.done), 64'd1);
      chk("basic_busy_end", 64'(ro_if.busy), 64'd0);
      chk("basic_dropped", 64'(ro_if.dropped), 64'd0);
      chk("basic_saturated", 64'(ro_if.saturated), 64'd0);
      chk_gaps(3, 4);
      ro_if.ro_sum_valid = 1'b0;
      // gapped valid: windows of 2 beats of 100 spaced by idle cycles
      ro_if.ro_sum = 19'd100;
      repeat (2) exp_q.push_back(20'd200);
      wr_times.delete();
      start(2, 2);
      for (int i = 0; i < 8; i++) begin
         ro_if.ro_sum_valid = (i % 2 == 0);
         cyc();
      end
      chk("gap_done", 64'(ro_if.done), 64'd1);
      chk_gaps(2, 4);
      ro_if.ro_sum_valid = 1'b0;
      // saturation
      ro_if.ro_sum = 19'h7FFFF;
      ro_if.ro_sum_valid = 1'b1;
      exp_q.push_back(20'hFFFFF);
      wr_times.delete();
      start(1, 4);
      repeat (4) cyc();
      chk("sat_wr_en", 64'(ro_if.fifo_wr_en), 64'd1);
      cyc();
      chk("sat_done", 64'(ro_if.done), 64'd1);
      chk("sat_flag", 64'(ro_if.saturated), 64'd1);
      // backpressure: fifo_full over 5 window-close cycles
      ro_if.ro_sum = 19'd5;
      exp_q.push_back(20'd10);
      exp_q.push_back(20'd14);
      wr_times.delete();
      start(2, 2);
      chk("bp_sat_cleared", 64'(ro_if.saturated), 64'd0);
      cyc();
      ro_if.fifo_full = 1'b1;
      repeat (5) cyc();
      chk("bp_hold_busy", 64'(ro_if.busy), 64'd1);
      chk("bp_hold_no_wr", 64'(ro_if.fifo_wr_en), 64'd0);
      chk("bp_dropped_4", 64'(ro_if.dropped), 64'd4);
      ro_if.fifo_full = 1'b0;
      cyc();
      chk("bp_release_wr", 64'(ro_if.fifo_wr_en), 64'd1);
      chk("bp_dropped_5", 64'(ro_if.dropped), 64'd5);
      ro_if.ro_sum = 19'd7;
      cyc();
      cyc();
      chk("bp_second_wr", 64'(ro_if.fifo_wr_en), 64'd1);
      cyc();
      chk("bp_done", 64'(ro_if.done), 64'd1);
      chk("bp_dropped_end", 64'(ro_if.dropped), 64'd5);
      chk_gaps(2, 2);
      // abort mid-window, then go together with stop from DONE
      ro_if.ro_sum = 19'd3;
      wr_times.delete();
      start(3, 4);
      cyc();
      cyc();
      ro_if.stop = 1'b1;
      cyc();
      chk("abort_done", 64'(ro_if.done), 64'd1);
      chk("abort_busy", 64'(ro_if.busy), 64'd0);
      chk("abort_no_wr", 64'(ro_if.fifo_wr_en), 64'd0);
      exp_q.push_back(20'd3);
      exp_q.push_back(20'd9);
      start(2, 0);
      ro_if.stop = 1'b0;
      chk("gostop_busy", 64'(ro_if.busy), 64'd1);
      chk("gostop_done", 64'(ro_if.done), 64'd0);
      cyc();
      ro_if.ro_sum = 19'd9;
      cyc();
      chk("cc0_wr_en", 64'(ro_if.fifo_wr_en), 64'd1);
      cyc();
      chk("cc0_done", 64'(ro_if.done), 64'd1);
      chk_gaps(2, 1);
      // reset while busy
      ro_if.ro_sum = 19'h7FFFF;
      exp_q.push_back(20'hFFFFF);
      start(5, 3);
      repeat (4) cyc();
      chk("rstmid_busy", 64'(ro_if.busy), 64'd1);
      chk("rstmid_sat", 64'(ro_if.saturated), 64'd1);
      chk("rstmid_data", 64'(ro_if.fifo_wr_data), 64'hFFFFF);
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      cyc();
      cyc();
      rst = 1'b0;
      ro_if.ro_sum_valid = 1'b0;
      cyc();
      cyc();
      chk("post_rst_done", 64'(ro_if.done), 64'd0);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ro_sample_window.md
Name: ro_sample_window

Overview:
- Upstream feeder of the ring-oscillator absorption FIFO.
- Takes the per-cycle RO adder-tree sum and accumulates it over a software-programmed window of `collect_cycles` valid beats.
- Saturates each window total to FIFO width and pushes one sample per window into the FIFO, until `num_samples` samples have been written or `stop` is raised.
- Provides `busy`/`done` status to the AFU control and MMIO.

Parameters:
- ADD_WIDTH, 19, width of the RO adder-tree sum (WIDTH + clog2(N)).
- FIFO_WIDTH, 20, width of one FIFO sample.
- COUNT_WIDTH, 43, width of `num_samples`/`collect_cycles` (matches count_t).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- go  in  1  single-cycle start pulse from MMIO.
- stop  in  1  abort request, level or pulse.
- num_samples  in  COUNT_WIDTH  samples to produce; sampled on go.
- collect_cycles  in  COUNT_WIDTH  valid beats per window; sampled on go.
- ro_sum_valid  in  1  ro_sum carries a new beat.
- ro_sum  in  ADD_WIDTH  RO adder-tree total, unsigned.
- fifo_full  in  1  absorption FIFO full.
- fifo_wr_en  out  1  FIFO write strobe, registered.
- fifo_wr_data  out  FIFO_WIDTH  window total, saturated, registered.
- busy  out  1  high in COLLECT or HOLD.
- done  out  1  high in DONE.
- saturated  out  1  sticky: at least one window clamped this run.
- dropped  out  COUNT_WIDTH  valid beats discarded while in HOLD this run.

Behaviour:
- Reset: state=IDLE. fifo_wr_en, fifo_wr_data, busy, done, saturated, dropped, accumulator, beat counter and sample counter all reset to 0.
- Latching on go:
  - num_samples is latched as-is.
  - collect_cycles is latched as cyc_r = max(collect_cycles, 1).
- States:
  - IDLE: on go, latch inputs, clear accumulator, counters, saturated and dropped. If num_samples==0 go to DONE, else go to COLLECT.
  - COLLECT: on each ro_sum_valid, acc <= sat_add(acc, ro_sum) and beat++. Invalid cycles do not advance the window. On the valid beat where beat==cyc_r-1, the window closes.
  - Window close when fifo_full==0: the next cycle has fifo_wr_en=1 and fifo_wr_data=sat_add(acc, ro_sum). The sample counter increments. acc and beat clear. If this was sample num_samples, go to DONE, else stay in COLLECT.
  - Window close when fifo_full==1: latch the total into hold_r and go to HOLD.
  - HOLD: each cycle fifo_full==0, emit hold_r (fifo_wr_en=1 next cycle), increment the sample counter, then go to DONE or COLLECT. While in HOLD, every ro_sum_valid beat is discarded and increments dropped (saturating at all-ones). Windows never overlap.
  - DONE: done=1. go restarts exactly as from IDLE (same latching and clearing). stop is ignored.
- fifo_wr_en is a one-cycle pulse per sample and is never asserted while fifo_full is sampled high.
- Saturating add: sat_add(a,b) = min(a+b, 2^FIFO_WIDTH-1), computed at FIFO_WIDTH+1 bits. Any clamp sets saturated.
- stop in COLLECT or HOLD: go to DONE next cycle, discarding the partial window and any hold_r contents. stop in IDLE is ignored.
- Simultaneous events:
  - stop with a window close in the same cycle: stop wins and no write occurs.
  - go while busy is ignored.
  - go and stop together in IDLE/DONE: go wins.
- Latency: final valid beat at cycle t gives fifo_wr_en at t+1 (FIFO not full). The last write at t+1 gives done=1 at t+2.
- Reset mid-operation: immediate return to the reset state. No partial write is emitted.

Decomposition:
- Shared package ro_pkg holds:
  - typedef count_t of COUNT_WIDTH bits;
  - the state enum {IDLE, COLLECT, HOLD, DONE};
  - the sat_add function, parameterised by width.
- One natural sub-module: ro_sat_accum (saturating accumulator with clear, enable and sticky saturate flag).
- The FSM and counters stay in ro_sample_window.

Test Plan:
- Basic run: num_samples=3, collect_cycles=4, ro_sum=10 valid every cycle, fifo_full=0 -> three writes of 40, one every 4 cycles; done one cycle after the third write; dropped=0, saturated=0.
- Gapped valid: collect_cycles=2, ro_sum_valid toggling 1/0, ro_sum=100 -> each write is 200, with 4 cycles between writes.
- Saturation: collect_cycles=4, ro_sum=2^19-1 -> fifo_wr_data=0xFFFFF, saturated=1.
- Backpressure: fifo_full=1 for 5 cycles at window close with valid every cycle -> state HOLD, dropped=5, write emitted the cycle after fifo_full falls, the next window starts fresh.
- Abort: stop mid-window with beat=2 of 4 -> no write, done next cycle. A following go restarts with cleared counters.
- Edge cases:
  - num_samples=0 -> done at the cycle after go with no writes.
  - collect_cycles=0 behaves as 1 -> one write per valid beat.
  - rst asserted while busy -> all outputs 0 asynchronously.
